// File: rtl/pulse_width_decoder.sv
// rtl/pulse_width_decoder.sv - stretched-pulse receiver: start/end strobes, width measure and classification
//
// Purpose: decodes a level pulse produced by an N-cycle pulse stretcher. Emits a
// 1-cycle strobe at the start and end of each pulse, measures the high width and
// classifies it as nominal, short, long, or stuck high beyond MAX_W cycles.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   in_pulse    in   stretched pulse (level), optionally from another clock domain
//   evt_pulse   out  1-cycle strobe, start of pulse
//   done_pulse  out  1-cycle strobe, end of a non-stuck pulse
//   width_out   out  measured high width, held until the next done_pulse
//   width_ok    out  with done_pulse: width == N
//   err_short   out  with done_pulse: width < N
//   err_long    out  with done_pulse: N < width <= MAX_W
//   stuck       out  level: input high for more than MAX_W cycles
module pulse_width_decoder #(
  parameter int N           = 4,
  parameter int MAX_W       = 64,
  parameter int SYNC_STAGES = 0,
  localparam int W          = $clog2(MAX_W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_pulse,
  output logic         evt_pulse,
  output logic         done_pulse,
  output logic [W-1:0] width_out,
  output logic         width_ok,
  output logic         err_short,
  output logic         err_long,
  output logic         stuck
);

  localparam logic [W-1:0] MAX_C = W'(MAX_W);
  localparam logic [W-1:0] N_C   = W'(N);

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_HIGH, ST_STUCK} state_t;

  logic in_s;
  logic sync_vld;

  // sync_vld marks the point where the synchroniser has been refilled after
  // reset; before that in_s shows the reset zeros, not the real line level,
  // and leaving ARM on them would report a level that was high through reset.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_s     = in_pulse;
    assign sync_vld = 1'b1;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        vld_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in_pulse};
        vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      end
    end
    assign in_s     = sync_q[SYNC_STAGES-1];
    assign sync_vld = vld_q[SYNC_STAGES-1];
  end

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   width_q, width_d;
  logic           evt_q, evt_d;
  logic           done_q, done_d;
  logic           ok_q, ok_d;
  logic           short_q, short_d;
  logic           long_q, long_d;
  logic           stuck_q, stuck_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ARM;
      cnt_q   <= '0;
      width_q <= '0;
      evt_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      evt_q   <= evt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      short_q <= short_d;
      long_q  <= long_d;
      stuck_q <= stuck_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:   if (sync_vld && !in_s) state_d = ST_IDLE;
      ST_IDLE:  if (in_s) state_d = ST_HIGH;
      ST_HIGH: begin
        if (!in_s)               state_d = ST_IDLE;
        else if (cnt_q == MAX_C) state_d = ST_STUCK;
      end
      ST_STUCK: if (!in_s) state_d = ST_IDLE;
      default:  state_d = ST_ARM;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    cnt_d   = cnt_q;
    width_d = width_q;
    evt_d   = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    stuck_d = stuck_q;
    case (state_q)
      ST_IDLE: begin
        if (in_s) begin
          cnt_d = W'(1);
          evt_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!in_s) begin
          done_d  = 1'b1;
          width_d = cnt_q;
          ok_d    = (cnt_q == N_C);
          short_d = (cnt_q < N_C);
          long_d  = (cnt_q > N_C);
        end else if (cnt_q == MAX_C) begin
          stuck_d = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      ST_STUCK: begin
        if (!in_s) stuck_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign evt_pulse  = evt_q;
  assign done_pulse = done_q;
  assign width_out  = width_q;
  assign width_ok   = ok_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
  assign stuck      = stuck_q;

endmodule
